// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS sequencing controller.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath enables and mux selects. Memory states wait on
// MemReady with a bounded wait counter; a timeout or an illegal opcode
// parks the FSM in HALT until reset.
//
// state   | meaning
// --------+---------------------------------------------------------
// FETCH   | read instruction at PC, PC+4 -> PC when MemReady
// DECODE  | branch target -> ALUOut, dispatch on opcode
// MEMADR  | A + signext(imm) -> ALUOut (lw/sw address)
// MEMRD   | read data memory at ALUOut into MDR
// MEMWB   | MDR -> register rt
// MEMWR   | write B to data memory at ALUOut
// EXEC    | R-type ALU operation on A, B
// RTYPEWB | ALUOut -> register rd
// BRANCH  | beq compare, PC <- ALUOut when ZF
// JUMP    | PC <- jump address
// IEXEC   | immediate ALU operation on A, signext(imm)
// IWB     | ALUOut -> register rt
// HALT    | stopped (illegal opcode or bus timeout), exit via rst only

module multicycle_control_fsm #(
  parameter int WAIT_LIMIT = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             ZF,
  input  logic             MemReady,
  output logic             PCEn,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       State,
  output logic             Halted,
  output logic             BusErr,
  output logic [CNT_W-1:0] InstrCount
);

  localparam int WAIT_W = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_wait_state;
  logic              timeout;

  // States that stall on MemReady share one wait counter. The counter holds
  // the number of stalled cycles so far; a stall seen while it already equals
  // WAIT_LIMIT is the timeout, while MemReady on that same cycle still succeeds.
  assign mem_wait_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  assign timeout        = mem_wait_state && !MemReady && (wait_cnt == WAIT_W'(WAIT_LIMIT));

  // State register, wait counter, sticky bus error and fetch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      BusErr     <= 1'b0;
      InstrCount <= '0;
    end else begin
      if ((state == S_FETCH) && MemReady)
        InstrCount <= InstrCount + CNT_W'(1);

      // Leaving a memory state always passes through zero, so every entry
      // to FETCH/MEMRD/MEMWR starts with a cleared counter.
      if (mem_wait_state && !MemReady && !timeout)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;

      if (timeout) begin
        BusErr <= 1'b1;
        state  <= S_HALT;
      end else begin
        case (state)
          S_FETCH:   if (MemReady) state <= S_DECODE;
          S_DECODE: begin
            case (opcode)
              OP_LW, OP_SW:                       state <= S_MEMADR;
              OP_RTYPE:                           state <= S_EXEC;
              OP_BEQ:                             state <= S_BRANCH;
              OP_J:                               state <= S_JUMP;
              OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state <= S_IEXEC;
              default:                            state <= S_HALT;
            endcase
          end
          S_MEMADR:  state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
          S_MEMRD:   if (MemReady) state <= S_MEMWB;
          S_MEMWR:   if (MemReady) state <= S_FETCH;
          S_MEMWB:   state <= S_FETCH;
          S_EXEC:    state <= S_RTYPEWB;
          S_RTYPEWB: state <= S_FETCH;
          S_BRANCH:  state <= S_FETCH;
          S_JUMP:    state <= S_FETCH;
          S_IEXEC:   state <= S_IWB;
          S_IWB:     state <= S_FETCH;
          S_HALT:    state <= S_HALT;
          default:   state <= S_HALT;
        endcase
      end
    end
  end

  // Output decode from the registered state; PCEn/IRWrite are Mealy on
  // MemReady/ZF, and reset kills every write/strobe enable immediately.
  always_comb begin
    PCEn     = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemToReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 3'b000;
    PCSource = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCEn    = MemReady;
      end
      S_DECODE:  ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemToReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 3'b010;
      end
      S_RTYPEWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 3'b001;
        PCSource = 2'b01;
        PCEn     = ZF;
      end
      S_JUMP: begin
        PCSource = 2'b10;
        PCEn     = 1'b1;
      end
      S_IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        case (opcode)
          OP_ANDI: ALUOp = 3'b011;
          OP_ORI:  ALUOp = 3'b100;
          OP_SLTI: ALUOp = 3'b101;
          default: ALUOp = 3'b000;
        endcase
      end
      S_IWB:     RegWrite = 1'b1;
      default:   ;
    endcase
    if (rst) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      MemRead  = 1'b0;
    end
  end

  // Debug view of the sequencer.
  assign State  = state;
  assign Halted = (state == S_HALT);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instruction sequences with
// literal expectations plus randomized instruction/MemReady traffic, all
// compared each cycle against an instruction-level reference model.
module tb_multicycle_control_fsm;

  localparam int WL = 4;
  localparam int CW = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic clk, rst, ZF, MemReady;
  logic [5:0] opcode;
  logic PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOp;
  logic [3:0] State;
  logic Halted, BusErr;
  logic [CW-1:0] InstrCount;

  multicycle_control_fsm #(.WAIT_LIMIT(WL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .ZF(ZF), .MemReady(MemReady),
    .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .State(State), .Halted(Halted), .BusErr(BusErr), .InstrCount(InstrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: instruction-level view. Decode expands an opcode into
  // the list of states it must visit; memory states consume MemReady.
  int m_state;
  int m_wait;
  bit m_buserr;
  int m_count;
  int m_plan[$];

  // Samples of the last stepped cycle, for directed literal checks.
  logic [3:0] cap_state;
  logic       cap_irw, cap_pcen, cap_rw, cap_m2r;
  logic [2:0] cap_aluop;
  logic [1:0] cap_pcs;
  logic [CW-1:0] cap_count;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [16:0] exp_ctrl(int st, logic [5:0] op, logic zf, logic mr);
    logic pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca, hlt;
    logic [1:0] srcb, pcs;
    logic [2:0] aop;
    {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca, hlt} = '0;
    srcb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcen = mr; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin srca = 1; aop = 3'b010; end
      7:  begin rdst = 1; rw = 1; end
      8:  begin srca = 1; aop = 3'b001; pcs = 2'b01; pcen = zf; end
      9:  begin pcs = 2'b10; pcen = 1; end
      10: begin
            srca = 1; srcb = 2'b10;
            if (op == OP_ANDI) aop = 3'b011;
            else if (op == OP_ORI) aop = 3'b100;
            else if (op == OP_SLTI) aop = 3'b101;
          end
      11: rw = 1;
      12: hlt = 1;
      default: ;
    endcase
    return {pcen, iord, mrd, mwr, irw, rdst, m2r, rw, srca, srcb, aop, pcs, hlt};
  endfunction

  task automatic model_reset();
    m_state = 0; m_wait = 0; m_buserr = 0; m_count = 0;
    m_plan.delete();
  endtask

  task automatic model_advance(input logic mr);
    if (m_state == 0 || m_state == 3 || m_state == 5) begin
      if (mr) begin
        m_wait = 0;
        if (m_state == 0) begin
          m_count = (m_count + 1) % (1 << CW);
          m_state = 1;
        end else begin
          m_state = (m_plan.size() > 0) ? m_plan.pop_front() : 0;
        end
      end else if (m_wait == WL) begin
        m_buserr = 1; m_state = 12; m_wait = 0; m_plan.delete();
      end else begin
        m_wait++;
      end
    end else if (m_state == 1) begin
      case (opcode)
        OP_LW:                              m_plan = '{2, 3, 4};
        OP_SW:                              m_plan = '{2, 5};
        OP_R:                               m_plan = '{6, 7};
        OP_BEQ:                             m_plan = '{8};
        OP_J:                               m_plan = '{9};
        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  m_plan = '{10, 11};
        default:                            m_plan = '{12};
      endcase
      m_state = m_plan.pop_front();
    end else if (m_state != 12) begin
      m_state = (m_plan.size() > 0) ? m_plan.pop_front() : 0;
    end
  endtask

  // One clock: drive at negedge, compare before posedge, advance model.
  task automatic step(input logic mr, input logic zf);
    MemReady = mr; ZF = zf;
    #2;
    chk("ctrl", {PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                 ALUSrcA, ALUSrcB, ALUOp, PCSource, Halted},
        exp_ctrl(m_state, opcode, zf, mr));
    chk("state", State, m_state);
    chk("buserr", BusErr, m_buserr);
    chk("instrcount", InstrCount, m_count[CW-1:0]);
    cap_state = State; cap_irw = IRWrite; cap_pcen = PCEn; cap_rw = RegWrite;
    cap_m2r = MemToReg; cap_aluop = ALUOp; cap_pcs = PCSource; cap_count = InstrCount;
    @(posedge clk);
    model_advance(mr);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; MemReady = 1'b1;
    #2;
    chk("rst_enables", {PCEn, IRWrite, RegWrite, MemWrite, MemRead}, 5'b0);
    chk("rst_state", State, 4'd0);
    chk("rst_count", InstrCount, '0);
    chk("rst_buserr", BusErr, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[];
    int pulses, steps, ok;
    rst = 1'b1; MemReady = 1'b0; ZF = 1'b0; opcode = OP_R;
    model_reset();
    @(negedge clk);

    // lw, MemReady tied high
    do_reset();
    opcode = OP_LW;
    exp_seq = '{0, 1, 2, 3, 4, 0};
    for (int i = 0; i < 6; i++) begin
      step(1, 0);
      chk("lw_seq", cap_state, exp_seq[i]);
      chk("lw_regwrite", cap_rw, (i == 4));
      if (i == 4) chk("lw_memtoreg", cap_m2r, 1'b1);
      if (i == 5) chk("lw_count", cap_count, 1);
    end

    // R-type then j
    do_reset();
    opcode = OP_R;
    exp_seq = '{0, 1, 6, 7, 0, 1, 9};
    for (int i = 0; i < 7; i++) begin
      if (i == 4) opcode = OP_J;
      step(1, 0);
      chk("rj_seq", cap_state, exp_seq[i]);
      if (i == 2) chk("exec_aluop", cap_aluop, 3'b010);
      if (i == 6) begin
        chk("jump_pcen", cap_pcen, 1'b1);
        chk("jump_pcsrc", cap_pcs, 2'b10);
        chk("rj_count", cap_count, 2);
      end
    end

    // beq taken then not taken
    do_reset();
    opcode = OP_BEQ;
    step(1, 0); step(1, 0); step(1, 1);
    chk("beq_taken_state", cap_state, 4'd8);
    chk("beq_taken_pcen", cap_pcen, 1'b1);
    chk("beq_taken_aluop", cap_aluop, 3'b001);
    step(1, 0); step(1, 0); step(1, 0);
    chk("beq_not_pcen", cap_pcen, 1'b0);
    chk("beq_not_aluop", cap_aluop, 3'b001);

    // MemReady on the limit cycle of MEMWR still succeeds
    do_reset();
    opcode = OP_SW;
    step(1, 0); step(1, 0); step(1, 0);
    for (int i = 0; i < WL; i++) step(0, 0);
    step(1, 0);
    chk("limit_ok_state", cap_state, 4'd5);
    chk("limit_ok_next", State, 4'd0);
    chk("limit_ok_buserr", BusErr, 1'b0);

    // FETCH stall of 3 cycles, then MEMWR timeout
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, 0);
      if (cap_irw) pulses++;
    end
    chk("fetch_wait_irw_last", cap_irw, 1'b1);
    chk("fetch_wait_pulses", pulses, 1);
    step(1, 0); step(1, 0);
    steps = 0;
    while (steps < 12 && State != 4'd12) begin
      step(0, 0);
      steps++;
    end
    chk("timeout_cycles", steps, WL + 1);
    chk("timeout_buserr", BusErr, 1'b1);
    chk("timeout_state", State, 4'd12);
    chk("timeout_halted", Halted, 1'b1);

    // HALT persists, then async reset pulse mid-cycle
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 1));
      if (cap_state != 4'd12) ok = 0;
    end
    chk("halt_persist", ok, 1);
    #3; rst = 1'b1; #1;
    chk("pulse_state", State, 4'd0);
    chk("pulse_count", InstrCount, '0);
    chk("pulse_buserr", BusErr, 1'b0);
    @(negedge clk); rst = 1'b0; model_reset();

    // Illegal opcode halts after DECODE
    opcode = OP_BAD;
    step(1, 0); step(1, 0);
    chk("illegal_halt", State, 4'd12);
    ok = 1;
    for (int i = 0; i < 20; i++) begin
      step(1, 0);
      if (cap_state != 4'd12 || !Halted) ok = 0;
    end
    chk("illegal_persist", ok, 1);

    // Reset mid-MEMWR drops MemWrite combinationally
    do_reset();
    opcode = OP_SW;
    step(1, 0); step(1, 0); step(1, 0);
    MemReady = 1'b0;
    #2;
    chk("memwr_before", MemWrite, 1'b1);
    rst = 1'b1; #1;
    chk("memwr_dropped", MemWrite, 1'b0);
    chk("memwr_rst_state", State, 4'd0);
    @(negedge clk); rst = 1'b0; model_reset();

    // Counter wrap at CNT_W=4
    do_reset();
    opcode = OP_R;
    for (int i = 0; i < 60; i++) step(1, 0);
    chk("wrap_15", InstrCount, 4'd15);
    step(1, 0);
    chk("wrap_0", InstrCount, 4'd0);
    for (int i = 0; i < 3; i++) step(1, 0);

    // Randomized traffic
    begin
      logic [5:0] ops[9];
      int halt_cycles;
      ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
      do_reset();
      halt_cycles = 0;
      for (int i = 0; i < 3000; i++) begin
        if (m_state == 12) begin
          halt_cycles++;
          if (halt_cycles > 4) begin
            do_reset();
            halt_cycles = 0;
          end
        end
        if (m_state == 0) begin
          if ($urandom_range(0, 24) == 0) opcode = 6'($urandom_range(0, 63));
          else opcode = ops[$urandom_range(0, 8)];
        end
        step($urandom_range(0, 9) < 6, $urandom_range(0, 1));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
